// File: rtl/freq_gate_meas.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a fixed
// gate window, converts the count to packed BCD with a bit-serial double dabble,
// then presents the binary and BCD results with a one-cycle valid strobe.
module freq_gate_meas #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIGITS      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  output logic                gate_active,
  output logic [CNT_W-1:0]    freq_bin,
  output logic [4*DIGITS-1:0] freq_bcd,
  output logic                overflow,
  output logic                result_valid
);

  localparam int unsigned TIMER_W = $clog2(GATE_CYCLES);
  localparam int unsigned BITS_W  = $clog2(CNT_W + 1);
  localparam int unsigned BCD_W   = 4 * DIGITS;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [BITS_W-1:0]  BITS_LAST  = BITS_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    StGate,
    StConvert,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync2_q, sync3_q;
  logic sig_edge;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_bin_q, ovf_bin_d;

  logic [CNT_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic               ovf_bcd_q, ovf_bcd_d;
  logic [BITS_W-1:0]  bit_q, bit_d;

  logic [CNT_W-1:0]   freq_bin_q, freq_bin_d;
  logic [BCD_W-1:0]   freq_bcd_q, freq_bcd_d;
  logic               overflow_q, overflow_d;

  // Double-dabble datapath: +3 on every nibble >= 5, then shift {bcd, bin} left.
  // The extra top bit of bcd_shift catches anything leaving the DIGITS range.
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W:0]   bcd_shift;

  // Two-flop synchronizer plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign sig_edge = sync2_q & ~sync3_q;

  // Nibble correction and one-bit shift of the BCD accumulator.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_sr_q[4*i +: 4] >= 4'd5) ? bcd_sr_q[4*i +: 4] + 4'd3
                                                        : bcd_sr_q[4*i +: 4];
    end
    bcd_shift = {bcd_adj, bin_sr_q[CNT_W-1]};
  end

  // Next-state logic for the gate / convert / done sequencer and its datapath.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    ovf_bin_d  = ovf_bin_q;
    bin_sr_d   = bin_sr_q;
    bcd_sr_d   = bcd_sr_q;
    ovf_bcd_d  = ovf_bcd_q;
    bit_d      = bit_q;
    freq_bin_d = freq_bin_q;
    freq_bcd_d = freq_bcd_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StGate: begin
        // An edge arriving while already at full scale marks the count as saturated.
        if (sig_edge) begin
          if (cnt_q == CNT_MAX) begin
            ovf_bin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (timer_q == TIMER_LAST) begin
          // cnt_d already includes an edge seen in this final gate cycle.
          timer_d   = '0;
          bin_sr_d  = cnt_d;
          bcd_sr_d  = '0;
          ovf_bcd_d = 1'b0;
          bit_d     = '0;
          state_d   = StConvert;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      StConvert: begin
        bin_sr_d  = bin_sr_q << 1;
        bcd_sr_d  = bcd_shift[BCD_W-1:0];
        ovf_bcd_d = ovf_bcd_q | bcd_shift[BCD_W];
        bit_d     = bit_q + BITS_W'(1);
        if (bit_q == BITS_LAST) begin
          // Results land as DONE is entered so they are valid alongside the strobe.
          freq_bin_d = cnt_q;
          freq_bcd_d = ovf_bcd_d ? {DIGITS{4'h9}} : bcd_sr_d;
          overflow_d = ovf_bin_q | ovf_bcd_d;
          state_d    = StDone;
        end
      end

      StDone: begin
        cnt_d     = '0;
        ovf_bin_d = 1'b0;
        ovf_bcd_d = 1'b0;
        state_d   = StGate;
      end

      default: begin
        state_d = StGate;
      end
    endcase
  end

  // Sequencer, counters, conversion registers and result latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGate;
      timer_q    <= '0;
      cnt_q      <= '0;
      ovf_bin_q  <= 1'b0;
      bin_sr_q   <= '0;
      bcd_sr_q   <= '0;
      ovf_bcd_q  <= 1'b0;
      bit_q      <= '0;
      freq_bin_q <= '0;
      freq_bcd_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      ovf_bin_q  <= ovf_bin_d;
      bin_sr_q   <= bin_sr_d;
      bcd_sr_q   <= bcd_sr_d;
      ovf_bcd_q  <= ovf_bcd_d;
      bit_q      <= bit_d;
      freq_bin_q <= freq_bin_d;
      freq_bcd_q <= freq_bcd_d;
      overflow_q <= overflow_d;
    end
  end

  // The state resets to GATE, so qualify with rst_n to hold gate_active low in reset.
  assign gate_active  = rst_n & (state_q == StGate);
  assign result_valid = (state_q == StDone);
  assign freq_bin     = freq_bin_q;
  assign freq_bcd     = freq_bcd_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/freq_gate_meas.md
Name: freq_gate_meas

Overview:
- Gated frequency-measurement stage that consumes an external test signal and produces a latched frequency result per gate window.
- Counts synchronized rising edges of `sig_in` over a fixed gate of GATE_CYCLES clocks.
- Converts the count to packed BCD with a sequential double-dabble, then presents binary + BCD results with a one-cycle valid strobe.
- Feeds the display/readout stage; runs continuously with no software start.

Parameters:
- GATE_CYCLES, 50_000_000: gate length in clk cycles (1 s at 50 MHz); minimum 2.
- CNT_W, 32: edge-counter and binary result width.
- DIGITS, 8: number of BCD digits in `freq_bcd`.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- sig_in  in  1  external signal under test; asynchronous to clk.
- gate_active  out  1  high while edges are being counted.
- freq_bin  out  CNT_W  latched edge count of the last completed gate.
- freq_bcd  out  4*DIGITS  latched packed BCD of the count; digit 0 is in bits [3:0].
- overflow  out  1  last result saturated, either in the binary counter or in the BCD range.
- result_valid  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Clock/reset: already decided — reset `rst_n`, asynchronous, active-low; clock `clk`.
- Reset values: freq_bin=0, freq_bcd=0, overflow=0, result_valid=0, gate_active=0. Synchronizer flops=0, edge counter=0, timer=0, state=GATE.
- Input path: 2-FF synchronizer plus a third flop for edge detect.
  - edge = sync2 & ~sync3.
  - Sync latency is 2 clk; an edge is registered on the 3rd clk after `sig_in` rises.
- States: GATE -> CONVERT -> DONE -> GATE.
- GATE:
  - gate_active=1; timer counts 0..GATE_CYCLES-1.
  - Each edge increments the edge counter.
  - The counter saturates at 2^CNT_W-1 and sets an internal ovf_bin flag; further edges are ignored.
  - An edge in the final gate cycle (timer=GATE_CYCLES-1) is counted.
  - On timer=GATE_CYCLES-1: latch the final count (including that cycle's edge) into the conversion shift register, clear the timer, go to CONVERT.
- CONVERT:
  - gate_active=0; edges are ignored (dead time).
  - Double dabble, one bit per clk, exactly CNT_W cycles.
  - Each cycle, every BCD nibble >=5 gets +3, then {bcd, bin} shifts left by 1.
  - The BCD accumulator is 4*DIGITS wide plus one carry-detect bit.
  - If any shifted-out bit or carry exceeds the DIGITS range, the value is >10^DIGITS-1: set ovf_bcd and force the BCD result to all 9s.
- DONE (1 clk):
  - freq_bin <= latched count; freq_bcd <= converted/forced value; overflow <= ovf_bin | ovf_bcd.
  - result_valid=1 this cycle only.
  - Clear the edge counter and ovf flags; go to GATE.
- Outputs hold between DONE cycles; there is no back-pressure.
- Measurement period is GATE_CYCLES+CNT_W+1 clks. First result_valid occurs at clk index GATE_CYCLES+CNT_W after reset release, counting from 0.
- Reset asserted mid-operation: immediate return to reset values. The partial count is discarded; no result_valid.
- Dead time: edges during CONVERT/DONE are lost by design. Gate accuracy is ±1 edge from synchronizer phase.

Test Plan:
- GATE_CYCLES=100, CNT_W=32, DIGITS=8, sig_in period 10 clk -> second result: freq_bin=10, freq_bcd=0x00000010, overflow=0; result_valid pulses every 133 clk.
- sig_in held low -> freq_bin=0, freq_bcd=0, overflow=0 on every result.
- sig_in period 2 clk (max rate), GATE_CYCLES=100 -> freq_bin=50, freq_bcd=0x00000050.
- CNT_W=8, GATE_CYCLES=600, period 2 -> count saturates: freq_bin=255, overflow=1; then drop sig_in to 0 -> next result freq_bin=0, overflow=0 (flag cleared per gate).
- DIGITS=2, CNT_W=8, GATE_CYCLES=300, period 2 -> freq_bin=150, freq_bcd=0x99, overflow=1.
- Assert rst_n low for 3 clk mid-CONVERT -> no result_valid, all outputs 0; next result_valid exactly GATE_CYCLES+CNT_W clk after release.
